// File: rtl/vid_pkg.sv
// Shared video-pipeline definitions: stage latency, pixel/window types and
// the output saturation helper used by the neighbourhood filters.
package vid_pkg;

    // Column-in to pixel-out latency of the Sobel stage
    localparam int SOBEL_LAT = 5;

    // Default pixel width used by the shared typedefs
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;

    // 3x3 neighbourhood, indexed [row][column]
    typedef pix_t win_t [3][3];

    // Clamp an unsigned value to the largest value representable in 'width' bits
    function automatic logic [31:0] saturate(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth delay line for the dv/hs/vs timing bundle, so that timing
// stays aligned with a pixel pipeline of the same depth.
module sync_delay #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic dv_i,
    input  logic hs_i,
    input  logic vs_i,
    output logic dv_o,
    output logic hs_o,
    output logic vs_o
);

    logic [DEPTH-1:0] dv_q, dv_d;
    logic [DEPTH-1:0] hs_q, hs_d;
    logic [DEPTH-1:0] vs_q, vs_d;

    // Push each timing signal one tap deeper every clock
    always_comb begin
        dv_d = (dv_q << 1) | DEPTH'(dv_i);
        hs_d = (hs_q << 1) | DEPTH'(hs_i);
        vs_d = (vs_q << 1) | DEPTH'(vs_i);
    end

    // Delay registers, cleared so no stale sync escapes after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q <= '0;
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            dv_q <= dv_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign dv_o = dv_q[DEPTH-1];
    assign hs_o = hs_q[DEPTH-1];
    assign vs_o = vs_q[DEPTH-1];

endmodule

// File: rtl/sobel3x3.sv
// Sobel gradient magnitude |gx|+|gy| over a 3x3 window built from the
// line buffer's per-cycle pixel column. Fixed 5-cycle pipeline, one pixel
// out per pixel in, timing signals delayed to match.
// Optional feature: define BORDER_MASK_EN to blank the outermost frame ring.
module sobel3x3
    import vid_pkg::*;
#(
    parameter int COLORDEPTH   = 8,
    parameter int SCREENWIDTH  = 1600,
    parameter int SCREENHEIGHT = 900,
    parameter int OUT_SHIFT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] col_i [2:0],
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] pix_o,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    // Gradient width: 4*max per side, signed difference, fits in COLORDEPTH+3
    localparam int GW = COLORDEPTH + 3;

    if (OUT_SHIFT < 0 || OUT_SHIFT > 3 || SCREENWIDTH < 3 || SCREENHEIGHT < 3) begin : g_bad_cfg
        $error("sobel3x3: OUT_SHIFT must be 0..3 and the screen at least 3x3");
    end

    logic [COLORDEPTH-1:0] win_q [3][3];
    logic [COLORDEPTH-1:0] win_d [3][3];
    logic signed [GW-1:0]  ext   [3][3];
    logic signed [GW-1:0]  gx_q, gx_d;
    logic signed [GW-1:0]  gy_q, gy_d;
    logic [GW-1:0]         abs_gx, abs_gy;
    logic [GW-1:0]         mag_q, mag_d;
    logic [GW-1:0]         shifted;
    logic [COLORDEPTH-1:0] pix_q, pix_d;
    logic                  dv_q, hs_q, vs_q;
    logic                  dv_s4, hs_s4, vs_s4;
    logic                  border;

    // Timing bundle runs one tap short; the last tap sits beside the pixel register
    sync_delay #(
        .DEPTH (SOBEL_LAT - 1)
    ) u_sync_delay (
        .clk  (clk),
        .rst  (rst),
        .dv_i (dv_i),
        .hs_i (hs_i),
        .vs_i (vs_i),
        .dv_o (dv_s4),
        .hs_o (hs_s4),
        .vs_o (vs_s4)
    );

    // Window shifts every clock: new column enters at c=0, oldest drops off c=2
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = col_i[r];
            win_d[r][1] = win_q[r][0];
            win_d[r][2] = win_q[r][1];
        end
    end

    // S1: horizontal and vertical Sobel kernels on the zero-extended window
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                ext[r][c] = signed'(GW'(win_q[r][c]));
            end
        end
        gx_d = (ext[0][0] + (ext[1][0] <<< 1) + ext[2][0])
             - (ext[0][2] + (ext[1][2] <<< 1) + ext[2][2]);
        gy_d = (ext[0][0] + (ext[0][1] <<< 1) + ext[0][2])
             - (ext[2][0] + (ext[2][1] <<< 1) + ext[2][2]);
    end

    // S2: L1 magnitude; both absolute values together still fit in GW bits
    always_comb begin
        abs_gx = gx_q[GW-1] ? unsigned'(-gx_q) : unsigned'(gx_q);
        abs_gy = gy_q[GW-1] ? unsigned'(-gy_q) : unsigned'(gy_q);
        mag_d  = abs_gx + abs_gy;
    end

    // S3: scale down, clamp to pixel range, then apply the border blank
    always_comb begin
        shifted = mag_q >> OUT_SHIFT;
        pix_d   = COLORDEPTH'(saturate(32'(shifted), COLORDEPTH));
        if (border) begin
            pix_d = '0;
        end
    end

`ifdef BORDER_MASK_EN
    localparam int CW = $clog2(SCREENWIDTH) + 1;
    localparam int RW = $clog2(SCREENHEIGHT) + 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Position tracking follows the pixel entering the output register, so
    // the mask lines up with dv_o without adding a stage
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (!dv_s4) begin
            col_d = '0;
        end else if (col_q != '1) begin
            col_d = col_q + 1'b1;
        end
        if (vs_s4) begin
            row_d = '0;
        end else if (dv_q && !dv_s4 && (row_q != RW'(SCREENHEIGHT - 1))) begin
            row_d = row_q + 1'b1;
        end
        border = (col_q == '0) || (col_q == CW'(SCREENWIDTH - 1)) ||
                 (row_q == '0) || (row_q == RW'(SCREENHEIGHT - 1));
    end

    // Position counters restart at the frame origin on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
`else
    // Without masking every pixel carries its raw gradient
    always_comb begin
        border = 1'b0;
    end
`endif

    // Pipeline registers: window, S1, S2, S3 and the final timing tap
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= '{default: '0};
            gx_q  <= '0;
            gy_q  <= '0;
            mag_q <= '0;
            pix_q <= '0;
            dv_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            win_q <= win_d;
            gx_q  <= gx_d;
            gy_q  <= gy_d;
            mag_q <= mag_d;
            pix_q <= pix_d;
            dv_q  <= dv_s4;
            hs_q  <= hs_s4;
            vs_q  <= vs_s4;
        end
    end

    assign pix_o = pix_q;
    assign dv_o  = dv_q;
    assign hs_o  = hs_q;
    assign vs_o  = vs_q;

endmodule
